// File: rtl/sym_cn_lut_loader_if.sv
// Page-word stream in, CN LUT RAM write port out, plus load control/status.
// load_chksum is present only when SYM_CN_LUT_LOAD_CHKSUM_EN is defined.
interface sym_cn_lut_loader_if #(
   parameter int LUT_PORT_SIZE = 2,
   parameter int PAGE_W        = 3
);
   logic                         load_start;
   logic                         load_offset;
   logic                         load_abort;
   logic [2*LUT_PORT_SIZE-1:0]   in_data;
   logic                         in_valid;
   logic                         in_ready;
   logic [LUT_PORT_SIZE-1:0]     lut_in_bank0;
   logic [LUT_PORT_SIZE-1:0]     lut_in_bank1;
   logic [PAGE_W-1:0]            page_write_addr;
   logic                         write_addr_offset;
   logic                         we;
   logic                         busy;
   logic                         load_done;
`ifdef SYM_CN_LUT_LOAD_CHKSUM_EN
   logic [2*LUT_PORT_SIZE-1:0]   load_chksum;
`endif

   modport master (
      input  load_start, load_offset, load_abort, in_data, in_valid,
      output in_ready, lut_in_bank0, lut_in_bank1, page_write_addr,
             write_addr_offset, we, busy, load_done
`ifdef SYM_CN_LUT_LOAD_CHKSUM_EN
      , output load_chksum
`endif
   );

   modport slave (
      output load_start, load_offset, load_abort, in_data, in_valid,
      input  in_ready, lut_in_bank0, lut_in_bank1, page_write_addr,
             write_addr_offset, we, busy, load_done
`ifdef SYM_CN_LUT_LOAD_CHKSUM_EN
      , input load_chksum
`endif
   );
endinterface

// File: rtl/sym_cn_lut_loader.sv
// Writes one full page set (PAGE_NUM pages, both banks) into a CN LUT frame slot.
// Optional load_chksum (XOR of accepted words) under SYM_CN_LUT_LOAD_CHKSUM_EN.
module sym_cn_lut_loader #(
   parameter int QUAN_SIZE       = 3,
   parameter int LUT_PORT_SIZE   = 2,
   parameter int ENTRY_ADDR      = 4,
   parameter int MULTI_FRAME_NUM = 2,
   parameter int PAGE_W          = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM)
) (
   input  logic                write_clk,
   input  logic                rstn,
   sym_cn_lut_loader_if.master bus
);
   localparam int                PAGE_NUM  = 1 << PAGE_W;
   localparam int                DW        = 2 * LUT_PORT_SIZE;
   localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGE_NUM - 1);

   if (QUAN_SIZE < 1 || LUT_PORT_SIZE < 1 || PAGE_W < 1) begin : g_param_chk
      $error("sym_cn_lut_loader: invalid parameters");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2} state_e;

   state_e                   state_q;
   logic [PAGE_W-1:0]        cnt_q;
   logic [PAGE_W-1:0]        addr_q;
   logic [LUT_PORT_SIZE-1:0] bank0_q;
   logic [LUT_PORT_SIZE-1:0] bank1_q;
   logic                     off_q;
   logic                     we_q;
   logic                     done_q;
   logic                     take_d;
   logic                     start_d;

   // An abort outranks both a coinciding beat and a coinciding start.
   assign take_d  = (state_q == LOAD) & bus.in_valid   & ~bus.load_abort;
   assign start_d = (state_q == IDLE) & bus.load_start & ~bus.load_abort;

   always_ff @(posedge write_clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         bank0_q <= '0;
         bank1_q <= '0;
         off_q   <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         we_q   <= take_d;
         done_q <= 1'b0;
         if (take_d) begin
            bank0_q <= bus.in_data[LUT_PORT_SIZE-1:0];
            bank1_q <= bus.in_data[DW-1:LUT_PORT_SIZE];
            addr_q  <= cnt_q;
            cnt_q   <= cnt_q + PAGE_W'(1);
         end
         unique case (state_q)
            IDLE: begin
               if (start_d) begin
                  off_q   <= bus.load_offset;
                  cnt_q   <= '0;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               if (bus.load_abort)                   state_q <= IDLE;
               else if (take_d && cnt_q == LAST_PAGE) state_q <= FLUSH;
            end
            // Last page's we is on the bus now; done follows one cycle later.
            FLUSH: begin
               state_q <= IDLE;
               done_q  <= ~bus.load_abort;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready          = (state_q == LOAD);
   assign bus.busy              = (state_q != IDLE);
   assign bus.we                = we_q;
   assign bus.load_done         = done_q;
   assign bus.lut_in_bank0      = bank0_q;
   assign bus.lut_in_bank1      = bank1_q;
   assign bus.page_write_addr   = addr_q;
   assign bus.write_addr_offset = off_q;

`ifdef SYM_CN_LUT_LOAD_CHKSUM_EN
   logic [DW-1:0] chksum_q;

   always_ff @(posedge write_clk) begin
      if (!rstn)        chksum_q <= '0;
      else if (start_d) chksum_q <= '0;
      else if (take_d)  chksum_q <= chksum_q ^ bus.in_data;
   end

   assign bus.load_chksum = chksum_q;
`endif
endmodule

// File: tb/tb_sym_cn_lut_loader.sv
// Randomized bench for sym_cn_lut_loader: transaction-level scoreboard of LUT writes.
// Checksum checks are enabled with SYM_CN_LUT_LOAD_CHKSUM_EN.
module tb_sym_cn_lut_loader;
   localparam int LPS = 2;
   localparam int PW  = 3;
   localparam int NPG = 8;
   localparam int DW  = 2 * LPS;

   logic write_clk = 1'b0;
   logic rstn      = 1'b0;
   always #5 write_clk = ~write_clk;

   sym_cn_lut_loader_if #(.LUT_PORT_SIZE(LPS), .PAGE_W(PW)) bus ();

   sym_cn_lut_loader #(
      .QUAN_SIZE(3), .LUT_PORT_SIZE(LPS), .ENTRY_ADDR(4), .MULTI_FRAME_NUM(2)
   ) dut (
      .write_clk (write_clk),
      .rstn      (rstn),
      .bus       (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   // Observed RAM writes and done pulses, stamped with the edge count.
   int            wq_cyc[$];
   logic [DW-1:0] wq_dat[$];
   logic [PW-1:0] wq_adr[$];
   logic          wq_off[$];
   int            dq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   always @(posedge write_clk) cyc <= cyc + 1;

   always @(negedge write_clk) begin
      if (mon_en) begin
         if (bus.we) begin
            wq_cyc.push_back(cyc);
            wq_dat.push_back({bus.lut_in_bank1, bus.lut_in_bank0});
            wq_adr.push_back(bus.page_write_addr);
            wq_off.push_back(bus.write_addr_offset);
         end
         if (bus.load_done) begin
            dq.push_back(cyc);
            chk("busy_in_done_cycle", 32'(bus.busy), 32'd0);
         end
      end
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_we"},     32'(bus.we),                32'd0);
      chk({nm, "_ready"},  32'(bus.in_ready),          32'd0);
      chk({nm, "_busy"},   32'(bus.busy),              32'd0);
      chk({nm, "_done"},   32'(bus.load_done),         32'd0);
      chk({nm, "_bank0"},  32'(bus.lut_in_bank0),      32'd0);
      chk({nm, "_bank1"},  32'(bus.lut_in_bank1),      32'd0);
      chk({nm, "_addr"},   32'(bus.page_write_addr),   32'd0);
      chk({nm, "_offset"}, 32'(bus.write_addr_offset), 32'd0);
   endtask

   // vmode: 0 valid held, 1 alternating, 2 random.
   // kill: 0 none, 1 abort, 2 reset; asserted once kill_at beats have been accepted.
   task automatic run_load(input string nm, input logic off, input int vmode,
                           input int kill, input int kill_at, input bit busy_start,
                           input bit use_fixed, input logic [NPG*DW-1:0] fixed);
      logic [DW-1:0] acc[$];
      int            acc_cyc[$];
      logic [DW-1:0] d;
      logic [DW-1:0] x;
      bit            v;
      bit            killed;
      int            g;
      int            n_exp;
      wq_cyc.delete(); wq_dat.delete(); wq_adr.delete(); wq_off.delete(); dq.delete();
      killed = 1'b0;
      g      = 0;
      bus.load_start  = 1'b1;
      bus.load_offset = off;
      @(posedge write_clk); #1;
      bus.load_start  = 1'b0;
      bus.load_offset = ~off;
      chk({nm, "_busy_after_start"}, 32'(bus.busy), 32'd1);
      while (acc.size() < NPG && g < 200) begin
         case (vmode)
            0:       v = 1'b1;
            1:       v = (g % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         d = use_fixed ? fixed[acc.size()*DW +: DW] : DW'($urandom);
         bus.in_valid = v;
         bus.in_data  = d;
         if (kill == 1 && acc.size() == kill_at) bus.load_abort = 1'b1;
         if (kill == 2 && acc.size() == kill_at) begin
            rstn           = 1'b0;
            bus.load_start = 1'b1;
         end
         if (busy_start && g == 2) begin
            bus.load_start  = 1'b1;
            bus.load_offset = ~off;
         end
         @(posedge write_clk); #1;
         bus.load_start = 1'b0;
         g++;
         if (kill != 0 && acc.size() == kill_at) begin
            killed = 1'b1;
            break;
         end
         if (v) begin
            acc.push_back(d);
            acc_cyc.push_back(cyc);
         end
      end
      bus.in_valid = 1'b0;
      if (killed && kill == 1) begin
         bus.load_abort = 1'b0;
         chk({nm, "_we_after_abort"},    32'(bus.we),       32'd0);
         chk({nm, "_busy_after_abort"},  32'(bus.busy),     32'd0);
         chk({nm, "_ready_after_abort"}, 32'(bus.in_ready), 32'd0);
      end
      if (killed && kill == 2) begin
         chk_all_zero({nm, "_rst"});
         bus.load_start = 1'b1;
         @(posedge write_clk); #1;
         rstn           = 1'b1;
         bus.load_start = 1'b0;
         @(posedge write_clk); #1;
         chk({nm, "_busy_after_rst"}, 32'(bus.busy), 32'd0);
      end
      repeat (3) @(posedge write_clk);
      #1;
      n_exp = killed ? kill_at : NPG;
      chk({nm, "_n_writes"}, 32'(wq_cyc.size()), 32'(n_exp));
      for (int i = 0; i < n_exp && i < wq_cyc.size(); i++) begin
         chk($sformatf("%s_addr%0d", nm, i), 32'(wq_adr[i]), 32'(i));
         chk($sformatf("%s_data%0d", nm, i), 32'(wq_dat[i]), 32'(acc[i]));
         chk($sformatf("%s_off%0d",  nm, i), 32'(wq_off[i]), 32'(off));
         chk($sformatf("%s_wcyc%0d", nm, i), 32'(wq_cyc[i]), 32'(acc_cyc[i]));
      end
      chk({nm, "_n_done"}, 32'(dq.size()), killed ? 32'd0 : 32'd1);
      if (!killed && dq.size() == 1 && acc_cyc.size() == NPG)
         chk({nm, "_done_cyc"}, 32'(dq[0]), 32'(acc_cyc[NPG-1] + 1));
      chk({nm, "_busy_end"},  32'(bus.busy),     32'd0);
      chk({nm, "_ready_end"}, 32'(bus.in_ready), 32'd0);
      chk({nm, "_we_end"},    32'(bus.we),       32'd0);
      if (!killed) begin
         chk({nm, "_off_held"}, 32'(bus.write_addr_offset), 32'(off));
`ifdef SYM_CN_LUT_LOAD_CHKSUM_EN
         x = '0;
         foreach (acc[i]) x ^= acc[i];
         chk({nm, "_chksum"}, 32'(bus.load_chksum), 32'(x));
`endif
      end
   endtask

   initial begin
      logic [NPG*DW-1:0] seq;
      logic [NPG*DW-1:0] pow;
      bus.load_start  = 1'b0;
      bus.load_offset = 1'b0;
      bus.load_abort  = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      for (int i = 0; i < NPG; i++) seq[i*DW +: DW] = DW'(i);
      pow = '0;
      for (int i = 0; i < 4; i++) pow[i*DW +: DW] = DW'(1 << i);
      mon_en = 1'b1;
      repeat (2) @(posedge write_clk);
      #1;
      chk_all_zero("reset");
      rstn = 1'b1;
      @(posedge write_clk); #1;

      run_load("seq8",    1'b1, 0, 0, 0, 1'b0, 1'b1, seq);
      run_load("stall",   1'b1, 1, 0, 0, 1'b0, 1'b0, seq);
      run_load("abort",   1'b1, 0, 1, 4, 1'b0, 1'b0, seq);
      run_load("restart", 1'b0, 2, 0, 0, 1'b0, 1'b0, seq);
      run_load("midrst",  1'b1, 0, 2, 6, 1'b0, 1'b0, seq);
      run_load("busystart", 1'b1, 0, 0, 0, 1'b1, 1'b0, seq);

      // Abort beats start in IDLE: nothing happens, offset keeps its value.
      bus.load_start  = 1'b1;
      bus.load_abort  = 1'b1;
      bus.load_offset = 1'b0;
      @(posedge write_clk); #1;
      bus.load_start = 1'b0;
      bus.load_abort = 1'b0;
      chk("idle_abort_busy",  32'(bus.busy),              32'd0);
      chk("idle_abort_ready", 32'(bus.in_ready),          32'd0);
      chk("idle_abort_off",   32'(bus.write_addr_offset), 32'd1);

      run_load("chk1248", 1'b0, 0, 0, 0, 1'b0, 1'b1, pow);
`ifdef SYM_CN_LUT_LOAD_CHKSUM_EN
      chk("chk1248_F", 32'(bus.load_chksum), 32'hF);
`endif

      for (int r = 0; r < 8; r++)
         run_load($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), 0, 0, 1'($urandom_range(0, 1)), 1'b0, seq);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sym_cn_lut_loader.md
Name: sym_cn_lut_loader

Overview:
- Write-side master for the symmetric CN IB-LUT RAM. It drives the LUT write port: lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset and we.
- Accepts a valid/ready stream of LUT page words from the IB table fetch logic. Writes one full page set (all pages, both banks) into the selected frame slot, then pulses done.
- Sits between the LUT update controller and the CN LUT RAM, in the write_clk domain.

Parameters:
- QUAN_SIZE, 3, message width; documentation only, matches the reader side.
- LUT_PORT_SIZE, 2, data width per bank.
- ENTRY_ADDR, 4, total LUT address width, including the frame-offset bit.
- MULTI_FRAME_NUM, 2, number of frame slots.
- PAGE_W, derived, ENTRY_ADDR-$clog2(MULTI_FRAME_NUM), default 3. PAGE_NUM = 2**PAGE_W = 8.

Ports:
- write_clk  in  1  sole clock.
- rstn  in  1  synchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a page-set load.
- load_offset  in  1  target frame slot, sampled with load_start.
- load_abort  in  1  cancels an in-progress load.
- in_data  in  2*LUT_PORT_SIZE  page word: [2*LUT_PORT_SIZE-1:LUT_PORT_SIZE] is bank1, [LUT_PORT_SIZE-1:0] is bank0.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word this cycle.
- lut_in_bank0  out  LUT_PORT_SIZE  write data, bank0.
- lut_in_bank1  out  LUT_PORT_SIZE  write data, bank1.
- page_write_addr  out  PAGE_W  page address.
- write_addr_offset  out  1  frame-slot offset.
- we  out  1  write enable.
- busy  out  1  state != IDLE.
- load_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, sampled on a write_clk edge with rstn=0:
  - State goes to IDLE and page counter to 0.
  - All outputs go to 0: we, in_ready, busy, load_done, lut_in_bank0/1, page_write_addr, write_addr_offset.
  - Reset mid-load drops we the next cycle. No load_done is issued.
- States:
  - IDLE: load_start=1 latches load_offset into write_addr_offset, clears the page counter and moves to LOAD.
  - LOAD: stays until the beat with page counter = PAGE_NUM-1 is accepted, then moves to FLUSH.
  - FLUSH: lasts one cycle, then returns to IDLE.
- in_ready = (state==LOAD), decoded directly from the state register.
- A transfer happens on an edge where in_valid & in_ready.
- Write timing:
  - A transfer at edge k registers lut_in_bank0/1 from in_data and page_write_addr from the page counter.
  - we=1 for the cycle following edge k, so the RAM captures the word at edge k+1.
  - With back-to-back transfers, we stays high continuously.
- Page counter increments by 1 per transfer. Pages are always written in ascending order 0..PAGE_NUM-1.
- A cycle with no transfer gives we=0 on the next cycle. Data and address outputs hold their last values.
- The last write (page PAGE_NUM-1) has its we cycle while the state is FLUSH. load_done=1 exactly on the cycle after that we cycle.
- busy=1 from the cycle after load_start through the FLUSH cycle. busy=0 in the load_done cycle.
- write_addr_offset holds its latched value until the next accepted load_start.
- load_start while busy is ignored and never queued.
- load_abort:
  - In LOAD or FLUSH: the next state is IDLE and we=0 the next cycle, even if a transfer coincides with the abort. The coinciding beat is dropped and no load_done is issued.
  - In IDLE: no effect. If load_abort and load_start are both high in IDLE, load_abort wins and the state stays IDLE.
- in_data is ignored whenever in_ready=0.

Optional Feature:
- Macro SYM_CN_LUT_LOAD_CHKSUM_EN.
- Defined:
  - Adds output load_chksum[2*LUT_PORT_SIZE-1:0], the XOR of all in_data words accepted in the current load.
  - Cleared to 0 on reset and on each accepted load_start.
  - Final value is valid and stable from the load_done cycle until the next accepted load_start.
- Undefined: the port and logic are absent. All other behaviour is identical.

Test Plan:
- Load 8 pages: rstn high, load_start=1 with load_offset=1, in_valid held high, in_data=0..7 -> we high for 8 consecutive cycles; page_write_addr 0..7; bank0=in_data[1:0], bank1=in_data[3:2]; write_addr_offset=1; load_done one cycle after the final we; busy then 0.
- Stalled stream: in_valid toggles 1,0,1,0 -> we gaps match the input gaps; page addresses 0..7 with none skipped or repeated; exactly 8 we cycles; load_done once.
- Abort and restart: load_abort after page 3 is written -> we=0 the next cycle, no load_done, busy=0. A new load_start with load_offset=0 restarts at page 0.
- Reset mid-load: rstn=0 after page 5 -> all outputs 0 the next cycle. load_start ignored while rstn=0.
- Start while busy: second load_start with load_offset=0 during a load_offset=1 load -> ignored; write_addr_offset stays 1; exactly 8 writes.
- Checksum (macro defined): in_data 1,2,4,8,0,0,0,0 -> load_chksum=4'hF at load_done.
